// File: rtl/divremsqrt_round_pipe.sv
// Two-stage rounding/packing pipeline behind the div/rem/sqrt shift-correction stage.
// Optional build macro DIVRND_FTZ_EN: flush tiny results to signed zero.
module divremsqrt_round_pipe #(
  parameter int NF  = 52,
  parameter int NE  = 11,
  parameter int MFW = 110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [MFW-1:0]    Mf,
  input  logic [NE+1:0]     Ue,
  input  logic              Sign,
  input  logic              StickyIn,
  input  logic [2:0]        Frm,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [NE+NF:0]    Res,
  output logic [2:0]        Flags
);

  localparam logic [2:0] FRM_RNE = 3'b000;
  localparam logic [2:0] FRM_RTZ = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  localparam logic [NE+1:0] EXP_OVF = (NE+2)'((1 << NE) - 1);

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  // Stage-1 state
  logic           s1_sign_q, s1_sign_d;
  logic [2:0]     s1_frm_q,  s1_frm_d;
  logic [NE:0]    s1_ue_q,   s1_ue_d;
  logic [NF:0]    s1_sig_q,  s1_sig_d;
  logic           s1_inc_q,  s1_inc_d;
  logic           s1_nx_q,   s1_nx_d;
  logic           s1_tiny_q, s1_tiny_d;

  // Stage-2 (output) state
  logic [NE+NF:0] res_q,   res_d;
  logic [2:0]     flags_q, flags_d;

  // Stage-1 combinational
  logic [NE:0]    ue_clamp;
  logic           rnd_l, rnd_g, rnd_s, rnd_rne, rnd_inc;

  // Stage-2 combinational
  logic [NF+1:0]  rnd_sum;
  logic [NE+1:0]  exp_sum;
  logic           ovf, to_inf, uf, nx;
  logic [NE-1:0]  exp_f;
  logic [NF-1:0]  frac_f;

  assign s2_adv   = ~s2_valid_q | OutReady;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  // Held high while reset is asserted so upstream never sees a stall from stale state.
  assign InReady  = ~reset | s1_adv;
  assign OutValid = s2_valid_q;
  assign Res      = res_q;
  assign Flags    = flags_q;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    ue_clamp = Ue[NE+1] ? '0 : Ue[NE:0];
    rnd_l    = Mf[MFW-1-NF];
    rnd_g    = Mf[MFW-2-NF];
    rnd_s    = (|Mf[MFW-3-NF:0]) | StickyIn;
    rnd_rne  = rnd_g & (rnd_l | rnd_s);

    // Encodings 101..111 are trapped upstream; round them as RNE.
    case (Frm)
      FRM_RNE: rnd_inc = rnd_rne;
      FRM_RTZ: rnd_inc = 1'b0;
      FRM_RDN: rnd_inc = Sign & (rnd_g | rnd_s);
      FRM_RUP: rnd_inc = ~Sign & (rnd_g | rnd_s);
      FRM_RMM: rnd_inc = rnd_g;
      default: rnd_inc = rnd_rne;
    endcase

    s1_valid_d = s1_adv ? InValid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_frm_d   = s1_frm_q;
    s1_ue_d    = s1_ue_q;
    s1_sig_d   = s1_sig_q;
    s1_inc_d   = s1_inc_q;
    s1_nx_d    = s1_nx_q;
    s1_tiny_d  = s1_tiny_q;
    if (s1_adv && InValid) begin
      s1_sign_d = Sign;
      s1_frm_d  = Frm;
      s1_ue_d   = ue_clamp;
      s1_sig_d  = Mf[MFW-1 -: NF+1];
      s1_inc_d  = rnd_inc;
      s1_nx_d   = rnd_g | rnd_s;
      s1_tiny_d = (ue_clamp == '0) & ~Mf[MFW-1];
    end
  end

  always_comb begin
    rnd_sum = {1'b0, s1_sig_q} + (NF+2)'(s1_inc_q);
    // The last term lifts a subnormal that rounds up into the minimum normal.
    exp_sum = (NE+2)'(s1_ue_q) + (NE+2)'(rnd_sum[NF+1])
            + (NE+2)'((s1_ue_q == '0) & rnd_sum[NF]);
    ovf     = exp_sum >= EXP_OVF;

    case (s1_frm_q)
      FRM_RTZ: to_inf = 1'b0;
      FRM_RDN: to_inf = s1_sign_q;
      FRM_RUP: to_inf = ~s1_sign_q;
      default: to_inf = 1'b1;
    endcase

    if (ovf) begin
      exp_f  = to_inf ? '1 : {{(NE-1){1'b1}}, 1'b0};
      frac_f = to_inf ? '0 : '1;
      nx     = 1'b1;
    end else begin
      exp_f  = exp_sum[NE-1:0];
      frac_f = rnd_sum[NF+1] ? '0 : rnd_sum[NF-1:0];
      nx     = s1_nx_q;
    end
    uf = s1_tiny_q & s1_nx_q;

`ifdef DIVRND_FTZ_EN
    // An exact zero keeps its clean flags; any other tiny value is flushed.
    if (s1_tiny_q && !(s1_sig_q == '0 && !s1_nx_q)) begin
      exp_f  = '0;
      frac_f = '0;
      uf     = 1'b1;
      nx     = 1'b1;
    end
`endif

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    if (s2_adv && s1_valid_q) begin
      res_d   = {s1_sign_q, exp_f, frac_f};
      flags_d = {ovf, uf, nx};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_frm_q  <= s1_frm_d;
    s1_ue_q   <= s1_ue_d;
    s1_sig_q  <= s1_sig_d;
    s1_inc_q  <= s1_inc_d;
    s1_nx_q   <= s1_nx_d;
    s1_tiny_q <= s1_tiny_d;
  end

endmodule

// File: tb/tb_divremsqrt_round_pipe.sv
// Self-checking bench for divremsqrt_round_pipe: directed corner cases plus
// randomized traffic scored against an arithmetic reference model.
module tb_divremsqrt_round_pipe;
  localparam int NF  = 52;
  localparam int NE  = 11;
  localparam int MFW = 110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, InValid, InReady, Sign, StickyIn, OutValid, OutReady;
  logic [MFW-1:0] Mf;
  logic [NE+1:0]  Ue;
  logic [2:0]     Frm;
  logic [NE+NF:0] Res;
  logic [2:0]     Flags;

  divremsqrt_round_pipe #(.NF(NF), .NE(NE), .MFW(MFW)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Mf(Mf), .Ue(Ue), .Sign(Sign), .StickyIn(StickyIn), .Frm(Frm),
    .OutValid(OutValid), .OutReady(OutReady), .Res(Res), .Flags(Flags)
  );

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flags;
    int          issue;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   in_fired;
  bit   use_dir, lat_on;
  logic [63:0] dir_res;
  logic [2:0]  dir_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: round the significand by mode, renormalise, then apply overflow/underflow rules.
  function automatic logic [66:0] model(input logic [MFW-1:0] mf, input logic [NE+1:0] ue,
                                        input logic sgn, input logic sticky, input logic [2:0] frm);
    longint unsigned sig, r, frac;
    int ex, e;
    bit g, s, inexact, up, tiny, inf;
    logic [NE-1:0] ef;
    logic [63:0] res;
    logic [2:0] fl;
    ex = ue[NE+1] ? 0 : int'(ue[NE:0]);
    sig = 64'(mf[MFW-1 -: NF+1]);
    g = mf[MFW-2-NF];
    s = (mf[MFW-3-NF:0] != '0) || sticky;
    inexact = g || s;
    case (frm)
      3'd1: up = 1'b0;
      3'd2: up = sgn && inexact;
      3'd3: up = !sgn && inexact;
      3'd4: up = g;
      default: up = g && ((sig % 2) == 1 || s);
    endcase
    r = sig + (up ? 64'd1 : 64'd0);
    if (r == (64'd1 << (NF+1))) begin
      e = ex + 1;
      frac = 0;
    end else begin
      e = (ex == 0 && r >= (64'd1 << NF)) ? 1 : ex;
      frac = r % (64'd1 << NF);
    end
    tiny = (ex == 0) && !mf[MFW-1];
    if (e >= (1 << NE) - 1) begin
      inf = (frm == 3'd1) ? 1'b0 : (frm == 3'd2) ? sgn : (frm == 3'd3) ? !sgn : 1'b1;
      res = inf ? {sgn, {NE{1'b1}}, {NF{1'b0}}} : {sgn, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
      fl  = 3'b101;
    end else begin
      ef  = NE'(e);
      res = {sgn, ef, NF'(frac)};
      fl  = {1'b0, tiny && inexact, inexact};
    end
`ifdef DIVRND_FTZ_EN
    if (tiny && !(sig == 0 && !inexact)) begin
      res = {sgn, {(NE+NF){1'b0}}};
      fl  = 3'b011;
    end
`endif
    return {fl, res};
  endfunction

  function automatic logic [MFW-1:0] mk_mf(input logic i, input logic [NF-1:0] f,
                                           input logic g, input logic [MFW-NF-3:0] rest);
    return {i, f, g, rest};
  endfunction

  // One clock: sample handshakes 1 time unit before the rising edge, then return at the falling edge.
  task automatic step();
    exp_t e, h;
    logic [66:0] m;
    #4;
    in_fired = 1'b0;
    if (reset && InValid && InReady) begin
      if (use_dir) begin
        e.res = dir_res;
        e.flags = dir_flags;
      end else begin
        m = model(Mf, Ue, Sign, StickyIn, Frm);
        e.res = m[63:0];
        e.flags = m[66:64];
      end
      e.issue = cyc;
      e.chk_lat = lat_on;
      sb.push_back(e);
      in_fired = 1'b1;
    end
    if (reset && OutValid && OutReady) begin
      if (sb.size() == 0) begin
        check("out_without_in", 64'(sb.size()), 64'd1);
      end else begin
        h = sb.pop_front();
        check("res", 64'(Res), h.res);
        check("flags", 64'(Flags), 64'(h.flags));
        if (h.chk_lat) check("latency", 64'(cyc - h.issue), 64'd2);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_op(input logic [MFW-1:0] mf, input logic [NE+1:0] ue, input logic sgn,
                          input logic sticky, input logic [2:0] frm);
    Mf = mf; Ue = ue; Sign = sgn; StickyIn = sticky; Frm = frm;
    InValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (in_fired) break;
    end
    check("accept_timeout", 64'(in_fired), 64'd1);
    InValid = 1'b0;
  endtask

  task automatic dir_op(input string tag, input logic [MFW-1:0] mf, input logic [NE+1:0] ue,
                        input logic sgn, input logic sticky, input logic [2:0] frm,
                        input logic [63:0] r, input logic [2:0] f);
    use_dir = 1'b1; lat_on = 1'b1;
    dir_res = r; dir_flags = f;
    drive_op(mf, ue, sgn, sticky, frm);
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check({"drain_", tag}, 64'(sb.size()), 64'd0);
    use_dir = 1'b0; lat_on = 1'b0;
  endtask

  task automatic rand_fields();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    Mf = w[MFW-1:0];
    if ($urandom_range(0, 3) == 0) Mf[MFW-2 -: NF] = '1;
    if ($urandom_range(0, 3) == 0) Mf[MFW-NF-3:0] = '0;
    if ($urandom_range(0, 2) == 0) Mf[MFW-1] = 1'b0;
    case ($urandom_range(0, 4))
      0: Ue = 13'($urandom_range(0, 2));
      1: Ue = 13'($urandom_range(2044, 2048));
      2: Ue = {1'b1, 12'($urandom)};
      3: Ue = 13'($urandom_range(1, 4095));
      default: Ue = 13'($urandom_range(1000, 1050));
    endcase
    Sign = 1'($urandom);
    StickyIn = ($urandom_range(0, 3) == 0);
    Frm = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic [NF-1:0] ones;
    logic [63:0] sub_res, neg_res;
    logic [2:0]  sub_fl, neg_fl;
    ones = '1;
    reset = 1'b0; InValid = 1'b0; OutReady = 1'b1; Sign = 1'b0; StickyIn = 1'b0;
    Frm = 3'd0; Ue = '0; Mf = '0; use_dir = 1'b0; lat_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #4;
    check("rst_inready", 64'(InReady), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #4;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_res", 64'(Res), 64'd0);
    check("rst_flags", 64'(Flags), 64'd0);
    @(negedge clk);

`ifdef DIVRND_FTZ_EN
    sub_res = 64'h0; sub_fl = 3'b011;
    neg_res = 64'h0; neg_fl = 3'b011;
`else
    sub_res = 64'h0010000000000000; sub_fl = 3'b011;
    neg_res = 64'h0000000000000001; neg_fl = 3'b000;
`endif

    dir_op("rne_carry", mk_mf(1'b1, ones, 1'b1, '0), 13'd1022, 1'b0, 1'b0, 3'd0, 64'h3FF0000000000000, 3'b001);
    dir_op("ovf_rne",   mk_mf(1'b1, ones, 1'b1, '0), 13'd2046, 1'b0, 1'b0, 3'd0, 64'h7FF0000000000000, 3'b101);
    dir_op("rtz_below", mk_mf(1'b1, ones, 1'b1, '0), 13'd2046, 1'b0, 1'b0, 3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b001);
    dir_op("ovf_rtz",   mk_mf(1'b1, '0, 1'b0, '0),   13'd2047, 1'b0, 1'b0, 3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b101);
    dir_op("ovf_rdn_n", mk_mf(1'b1, '0, 1'b0, '0),   13'd2047, 1'b1, 1'b0, 3'd2, 64'hFFF0000000000000, 3'b101);
    dir_op("sub_norm",  mk_mf(1'b0, ones, 1'b1, '0), 13'd0,    1'b0, 1'b0, 3'd3, sub_res, sub_fl);
    dir_op("exact_1p5", mk_mf(1'b1, 52'h8000000000000, 1'b0, '0), 13'd1023, 1'b0, 1'b0, 3'd2, 64'h3FF8000000000000, 3'b000);
    dir_op("exact_zero", '0, 13'd0, 1'b1, 1'b0, 3'd0, 64'h8000000000000000, 3'b000);
    dir_op("neg_ue",    mk_mf(1'b0, 52'h1, 1'b0, '0), 13'h1FFB, 1'b0, 1'b0, 3'd0, neg_res, neg_fl);
    dir_op("sticky_rup", mk_mf(1'b1, '0, 1'b0, '0),  13'd1023, 1'b0, 1'b1, 3'd3, 64'h3FF0000000000001, 3'b001);

    // Backpressure: third op must stall until the output drains.
    OutReady = 1'b0;
    rand_fields(); drive_op(Mf, Ue, Sign, StickyIn, Frm);
    rand_fields(); drive_op(Mf, Ue, Sign, StickyIn, Frm);
    rand_fields(); InValid = 1'b1;
    #4;
    check("bp_inready", 64'(InReady), 64'd0);
    check("bp_outvalid", 64'(OutValid), 64'd1);
    check("bp_hold", 64'(Res), sb[0].res);
    @(negedge clk); cyc++;
    step(); step();
    OutReady = 1'b1;
    drive_op(Mf, Ue, Sign, StickyIn, Frm);
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("bp_drain", 64'(sb.size()), 64'd0);

    // Reset with both stages full.
    OutReady = 1'b0;
    rand_fields(); drive_op(Mf, Ue, Sign, StickyIn, Frm);
    rand_fields(); drive_op(Mf, Ue, Sign, StickyIn, Frm);
    reset = 1'b0;
    #4;
    check("mid_rst_inready", 64'(InReady), 64'd1);
    @(negedge clk); cyc++;
    reset = 1'b1;
    sb.delete();
    #4;
    check("mid_rst_outvalid", 64'(OutValid), 64'd0);
    check("mid_rst_res", 64'(Res), 64'd0);
    check("mid_rst_inready2", 64'(InReady), 64'd1);
    @(negedge clk); cyc++;
    OutReady = 1'b1;
    dir_op("post_rst", mk_mf(1'b1, 52'h8000000000000, 1'b0, '0), 13'd1023, 1'b0, 1'b0, 3'd2, 64'h3FF8000000000000, 3'b000);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      InValid  = ($urandom_range(0, 9) < 7);
      OutReady = ($urandom_range(0, 9) < 7);
      step();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
